hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl_pkg.sv | 32 +++
 rtl/hilo_decode.sv | 29 ++
 rtl/hilo_ctrl.sv | 103 ++++++++++
 tb/tb_hilo_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg: shared encodings, FSM states and defaults for the HI/LO control block
package hilo_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam int DIV_LIMIT_DEF = 40;

    typedef enum logic {
        IDLE     = 1'b0,
        DIV_WAIT = 1'b1
    } hilo_state_e;

    // One-hot instruction class; signed/unsigned variants share a class
    typedef struct packed {
        logic mfhi;
        logic mthi;
        logic mflo;
        logic mtlo;
        logic mul;
        logic div;
    } hilo_cls_t;

endpackage

// File: rtl/hilo_decode.sv
// hilo_decode: combinational instruction to one-hot HI/LO class decoder
module hilo_decode
    import hilo_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        valid,
    output hilo_cls_t   cls
);

    logic       sp;
    logic [5:0] fn;
    logic       unused_fields;

    assign sp            = valid && (inst[31:26] == OP_SPECIAL);
    assign fn            = inst[5:0];
    assign unused_fields = ^inst[25:6];

    // Match funct only for opcode-0 instructions that are real
    always_comb begin
        cls      = '0;
        cls.mfhi = sp && (fn == FN_MFHI);
        cls.mthi = sp && (fn == FN_MTHI);
        cls.mflo = sp && (fn == FN_MFLO);
        cls.mtlo = sp && (fn == FN_MTLO);
        cls.mul  = sp && (fn == FN_MULT || fn == FN_MULTU);
        cls.div  = sp && (fn == FN_DIV || fn == FN_DIVU);
    end

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO architectural registers, divide wait FSM and ID stall generation
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int DIV_LIMIT = DIV_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_inst,
    input  logic [31:0] ex_inst,
    input  logic        ex_valid,
    input  logic [31:0] rs_data,
    input  logic        md_running,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        div_busy,
    output logic        div_timeout
);

    localparam logic [5:0] LIM_M1 = 6'(DIV_LIMIT - 1);

    hilo_cls_t   id_cls;
    hilo_cls_t   ex_cls;
    hilo_state_e state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_d, lo_d;
    logic        div_timeout_q, div_timeout_d;

    hilo_decode u_id_dec (
        .inst  (id_inst),
        .valid (1'b1),
        .cls   (id_cls)
    );

    hilo_decode u_ex_dec (
        .inst  (ex_inst),
        .valid (ex_valid),
        .cls   (ex_cls)
    );

    assign div_busy    = (state_q == DIV_WAIT);
    assign div_timeout = div_timeout_q;

    // Read port and freeze request; a divide in EX blocks ID before the FSM has moved
    always_comb begin
        mf_data = ex_cls.mfhi ? hi_q : (ex_cls.mflo ? lo_q : 32'h0);
        stall   = (div_busy || ex_cls.div) && (|id_cls);
    end

    // Next state: EX writes only in IDLE; in DIV_WAIT the divider owns HI/LO
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        div_timeout_d = div_timeout_q;
        if (state_q == IDLE) begin
            if (ex_cls.div) begin
                state_d = DIV_WAIT;
                cnt_d   = '0;
            end else if (ex_cls.mul) begin
                hi_d = md_hi;
                lo_d = md_lo;
            end else if (ex_cls.mthi) begin
                hi_d = rs_data;
            end else if (ex_cls.mtlo) begin
                lo_d = rs_data;
            end
        end else begin
            cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
            if (!md_running && cnt_q != 6'd0) begin
                hi_d    = md_hi;
                lo_d    = md_lo;
                state_d = IDLE;
            end else if (md_running && cnt_q >= LIM_M1) begin
                div_timeout_d = 1'b1;
                state_d       = IDLE;
            end
        end
    end

    // State and architectural registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            div_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            div_timeout_q <= div_timeout_d;
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed stimulus with a cycle-tagged expectation scoreboard
module tb_hilo_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] MFHI  = 32'h0000_4010;
    localparam logic [31:0] MTHI  = 32'h0080_0011;
    localparam logic [31:0] MFLO  = 32'h0000_4812;
    localparam logic [31:0] MTLO  = 32'h00A0_0013;
    localparam logic [31:0] MULT  = 32'h0085_0018;
    localparam logic [31:0] MULTU = 32'h0085_0019;
    localparam logic [31:0] DIV   = 32'h0085_001A;
    localparam logic [31:0] DIVU  = 32'h0085_001B;

    localparam int S_HI = 0, S_LO = 1, S_MF = 2, S_ST = 3, S_BZ = 4, S_TO = 5;

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_inst, ex_inst, rs_data, md_hi, md_lo;
    logic        ex_valid, md_running;
    logic [31:0] hi_q, lo_q, mf_data;
    logic        stall, div_busy, div_timeout;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    hilo_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_inst     (id_inst),
        .ex_inst     (ex_inst),
        .ex_valid    (ex_valid),
        .rs_data     (rs_data),
        .md_running  (md_running),
        .md_hi       (md_hi),
        .md_lo       (md_lo),
        .hi_q        (hi_q),
        .lo_q        (lo_q),
        .mf_data     (mf_data),
        .stall       (stall),
        .div_busy    (div_busy),
        .div_timeout (div_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get(input int s);
        case (s)
            S_HI:    return hi_q;
            S_LO:    return lo_q;
            S_MF:    return mf_data;
            S_ST:    return {31'b0, stall};
            S_BZ:    return {31'b0, div_busy};
            default: return {31'b0, div_timeout};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input int s, input logic [31:0] v, input string nm);
        exp_t e;
        e.at  = cyc + dc;
        e.sig = s;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic set_ex(input logic [31:0] inst, input logic v, input logic [31:0] rs);
        ex_inst  = inst;
        ex_valid = v;
        rs_data  = rs;
    endtask

    // Monitor: mid-cycle, compare every expectation due now; drop any overdue one as missed
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                checks++;
                if (get(sb[i].sig) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].nm, cyc, get(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                errors++;
                $display("FAIL %s missed cyc=%0d want=%h", sb[i].nm, sb[i].at, sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        id_inst = NOP;
        set_ex(NOP, 1'b0, 32'h0);
        md_running = 1'b0;
        md_hi = 32'h0;
        md_lo = 32'h0;
        tick();
        expect_at(0, S_HI, 32'h0, "rst_hi");
        expect_at(0, S_LO, 32'h0, "rst_lo");
        expect_at(0, S_ST, 32'h0, "rst_stall");
        expect_at(0, S_BZ, 32'h0, "rst_busy");
        expect_at(0, S_TO, 32'h0, "rst_timeout");
        tick();
        rst = 1'b0;

        tick();
        set_ex(MULT, 1'b1, 32'h0);
        md_hi = 32'hFFFF_FFFF;
        md_lo = 32'hFFFF_FFFE;
        expect_at(0, S_HI, 32'h0, "mult_not_early");
        expect_at(1, S_HI, 32'hFFFF_FFFF, "mult_hi");
        expect_at(1, S_LO, 32'hFFFF_FFFE, "mult_lo");
        tick();
        set_ex(MULTU, 1'b0, 32'h0);
        md_hi = 32'h1;
        md_lo = 32'h2;
        expect_at(1, S_HI, 32'hFFFF_FFFF, "bubble_multu_hi");
        tick();
        set_ex(MTHI, 1'b1, 32'h1234_5678);
        expect_at(1, S_HI, 32'h1234_5678, "mthi_hi");
        tick();
        set_ex(MFHI, 1'b1, 32'h0);
        expect_at(0, S_MF, 32'h1234_5678, "fwd_mfhi");
        tick();
        set_ex(MTLO, 1'b1, 32'hCAFE_F00D);
        expect_at(0, S_MF, 32'h0, "mf_none");
        expect_at(1, S_LO, 32'hCAFE_F00D, "mtlo_lo");
        expect_at(1, S_HI, 32'h1234_5678, "mtlo_keeps_hi");
        tick();
        set_ex(MFLO, 1'b1, 32'h0);
        expect_at(0, S_MF, 32'hCAFE_F00D, "mflo");
        tick();
        set_ex(MFHI, 1'b0, 32'h0);
        expect_at(0, S_MF, 32'h0, "mf_bubble");

        tick();
        set_ex(DIVU, 1'b1, 32'h0);
        id_inst = MFLO;
        md_running = 1'b1;
        md_hi = 32'h9;
        md_lo = 32'h9;
        expect_at(0, S_ST, 32'h1, "div_ex_stall");
        expect_at(0, S_BZ, 32'h0, "div_ex_busy");
        tick();
        set_ex(NOP, 1'b0, 32'h0);
        for (int k = 0; k < 31; k++) begin
            expect_at(0, S_BZ, 32'h1, "div_busy");
            expect_at(0, S_ST, 32'h1, "div_stall");
            if (k == 10) begin
                expect_at(0, S_HI, 32'h1234_5678, "div_hi_hold");
                expect_at(0, S_LO, 32'hCAFE_F00D, "div_lo_hold");
            end
            tick();
        end
        md_running = 1'b0;
        md_hi = 32'h3;
        md_lo = 32'h0E;
        expect_at(0, S_BZ, 32'h1, "div_busy_last");
        expect_at(0, S_ST, 32'h1, "div_stall_last");
        expect_at(1, S_HI, 32'h3, "div_hi");
        expect_at(1, S_LO, 32'h0E, "div_lo");
        expect_at(1, S_BZ, 32'h0, "div_done_idle");
        expect_at(1, S_ST, 32'h0, "div_stall_release");
        tick();
        tick();
        id_inst = NOP;
        set_ex(MFLO, 1'b1, 32'h0);
        expect_at(0, S_MF, 32'h0E, "div_mflo");

        tick();
        set_ex(DIV, 1'b1, 32'h0);
        md_running = 1'b1;
        md_hi = 32'hAA;
        md_lo = 32'hBB;
        expect_at(0, S_ST, 32'h0, "to_no_hilo_in_id");
        tick();
        set_ex(NOP, 1'b0, 32'h0);
        for (int k = 0; k < 40; k++) begin
            expect_at(0, S_BZ, 32'h1, "to_busy");
            expect_at(0, S_TO, 32'h0, "to_not_early");
            tick();
        end
        expect_at(0, S_TO, 32'h1, "to_flag");
        expect_at(0, S_BZ, 32'h0, "to_idle");
        expect_at(0, S_HI, 32'h3, "to_hi_hold");
        expect_at(0, S_LO, 32'h0E, "to_lo_hold");
        tick();
        set_ex(MTHI, 1'b1, 32'h55);
        expect_at(1, S_HI, 32'h55, "to_mthi_after");
        expect_at(1, S_TO, 32'h1, "to_sticky");
        tick();

        set_ex(DIVU, 1'b1, 32'h0);
        id_inst = MFHI;
        expect_at(0, S_ST, 32'h1, "rd_ex_stall");
        tick();
        set_ex(NOP, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            expect_at(0, S_BZ, 32'h1, "rd_busy");
            tick();
        end
        rst = 1'b1;
        #1;
        expect_at(0, S_HI, 32'h0, "rd_hi");
        expect_at(0, S_LO, 32'h0, "rd_lo");
        expect_at(0, S_ST, 32'h0, "rd_stall");
        expect_at(0, S_BZ, 32'h0, "rd_busy_clr");
        expect_at(0, S_TO, 32'h0, "rd_timeout_clr");
        tick();
        rst = 1'b0;
        id_inst = NOP;
        md_running = 1'b0;
        set_ex(MTLO, 1'b1, 32'h77);
        expect_at(1, S_LO, 32'h77, "resume_mtlo");
        expect_at(1, S_BZ, 32'h0, "resume_idle");
        tick();
        set_ex(NOP, 1'b0, 32'h0);
        tick();
        tick();
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
